mem_arbiter: RTL and testbench

Shares one unified single-port memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the pipelined MIPS core. Each access is held for a fixed number of memory wait cycles. The block returns a one-cycle ready handshake to each requester, and the hazard logic uses it to stall the pipeline. It sits between the `mips` core and the memory, replacing the separate imem/dmem pair.

---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/mem_arb_wait_ctr.sv | 26 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter of the MIPS core.
package mips_mem_pkg;

  localparam int unsigned ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IFETCH,
    ARB_DATA
  } arb_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } arb_port_t;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Loadable down-counter timing the memory wait cycles; holds at zero.
module mem_arb_wait_ctr
  import mips_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ARB_CNT_W-1:0] value,
  output logic                 zero
);

  logic [ARB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - ARB_CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between the IF and MEM stage ports.
// Define MEM_ARB_RR_EN for round-robin tie-break instead of data-port priority.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifreq,
  input  logic [31:0] ifaddr,
  output logic        ifready,
  output logic [31:0] ifrdata,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic        dready,
  output logic [31:0] drdata,
  output logic        mreq,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic        mwe,
  input  logic [31:0] mrdata
);

  localparam logic [ARB_CNT_W-1:0] WAIT_INIT = ARB_CNT_W'(LATENCY - 1);

  arb_state_t  state_q, state_d;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic        grant_if, grant_d;
  logic        cnt_zero;
  logic        pick_d;

`ifdef MEM_ARB_RR_EN
  arb_port_t last_served;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_served <= PORT_IF;
    end else if (grant_d) begin
      last_served <= PORT_D;
    end else if (grant_if) begin
      last_served <= PORT_IF;
    end
  end

  // On a tie the port not served last takes the memory.
  assign pick_d = dreq & (~ifreq | (last_served == PORT_IF));
`else
  assign pick_d = dreq;
`endif

  mem_arb_wait_ctr u_wait (
    .clk   (clk),
    .reset (reset),
    .load  (grant_if | grant_d),
    .value (WAIT_INIT),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end else if (grant_d) begin
      lat_addr  <= daddr;
      lat_wdata <= dwdata;
      lat_we    <= dwe;
    end else if (grant_if) begin
      lat_addr  <= ifaddr;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end
  end

  // Final-cycle handoff grants the other port directly, skipping ARB_IDLE.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_d) begin
          grant_d = 1'b1;
          state_d = ARB_DATA;
        end else if (ifreq) begin
          grant_if = 1'b1;
          state_d  = ARB_IFETCH;
        end
      end
      ARB_IFETCH: begin
        if (cnt_zero) begin
          if (dreq) begin
            grant_d = 1'b1;
            state_d = ARB_DATA;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      ARB_DATA: begin
        if (cnt_zero) begin
          if (ifreq) begin
            grant_if = 1'b1;
            state_d  = ARB_IFETCH;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mreq    = 1'b0;
    maddr   = '0;
    mwdata  = '0;
    mwe     = 1'b0;
    ifready = 1'b0;
    ifrdata = '0;
    dready  = 1'b0;
    drdata  = '0;
    if (state_q != ARB_IDLE) begin
      mreq   = 1'b1;
      maddr  = lat_addr;
      mwdata = lat_wdata;
      if (cnt_zero) begin
        mwe = lat_we;
        if (state_q == ARB_IFETCH) begin
          ifready = 1'b1;
          ifrdata = mrdata;
        end else begin
          dready = 1'b1;
          drdata = mrdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed literals.
module tb_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ifreq, dreq, dwe;
  logic [31:0] ifaddr, daddr, dwdata, mrdata;
  logic        ifready, dready, mreq, mwe;
  logic [31:0] ifrdata, drdata, maddr, mwdata;

  logic        reset1, ifreq1, dreq1, dwe1;
  logic [31:0] ifaddr1, daddr1, dwdata1, mrdata1;
  logic        ifready1, dready1, mreq1, mwe1;
  logic [31:0] ifrdata1, drdata1, maddr1, mwdata1;

  logic [31:0] mem    [32];
  logic [31:0] shadow [32];

  int checks = 0;
  int passes = 0;

  mem_arbiter #(.LATENCY(LAT)) u0 (
    .clk(clk), .reset(reset),
    .ifreq(ifreq), .ifaddr(ifaddr), .ifready(ifready), .ifrdata(ifrdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dready(dready), .drdata(drdata),
    .mreq(mreq), .maddr(maddr), .mwdata(mwdata), .mwe(mwe), .mrdata(mrdata)
  );

  mem_arbiter #(.LATENCY(1)) u1 (
    .clk(clk), .reset(reset1),
    .ifreq(ifreq1), .ifaddr(ifaddr1), .ifready(ifready1), .ifrdata(ifrdata1),
    .dreq(dreq1), .dwe(dwe1), .daddr(daddr1), .dwdata(dwdata1),
    .dready(dready1), .drdata(drdata1),
    .mreq(mreq1), .maddr(maddr1), .mwdata(mwdata1), .mwe(mwe1), .mrdata(mrdata1)
  );

  assign mrdata  = mem[maddr[6:2]];
  assign mrdata1 = mem[maddr1[6:2]];

  always @(posedge clk) begin
    if (mwe) mem[maddr[6:2]] <= mwdata;
  end

  assert property (@(posedge clk) disable iff (reset) (ifreq && !ifready) |=> ifreq);
  assert property (@(posedge clk) disable iff (reset) (dreq && !dready) |=> dreq);

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i == 1) ? 32'h2008_0005 : (32'hA500_0000 | i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
  endtask

  // Drive point: just after the active edge. Look point: after the model's negedge compare.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #5;
  endtask

  // ---------------- transaction-level reference model ----------------
  int          srv;   // 0 none, 1 fetch, 2 data
  int          left;  // cycles of the current access still to run, including this one
  logic [31:0] s_addr, s_wdata;
  logic        s_we, last_d;
  logic        fin, e_mreq, e_mwe, e_ifr, e_dr, prefer_d;
  logic [31:0] e_maddr, e_mwdata, e_ifd, e_dd;

  task automatic take_d();
    srv = 2; left = LAT; s_addr = daddr; s_wdata = dwdata; s_we = dwe; last_d = 1'b1;
  endtask

  task automatic take_if();
    srv = 1; left = LAT; s_addr = ifaddr; s_wdata = '0; s_we = 1'b0; last_d = 1'b0;
  endtask

  initial begin
    srv = 0; left = 0; s_addr = '0; s_wdata = '0; s_we = 1'b0; last_d = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        srv = 0; left = 0; last_d = 1'b0;
      end
      fin      = (srv != 0) && (left == 1);
      e_mreq   = (srv != 0);
      e_maddr  = e_mreq ? s_addr : '0;
      e_mwdata = e_mreq ? s_wdata : '0;
      e_mwe    = fin && s_we;
      e_ifr    = fin && (srv == 1);
      e_dr     = fin && (srv == 2);
      e_ifd    = e_ifr ? shadow[s_addr[6:2]] : '0;
      e_dd     = e_dr ? shadow[s_addr[6:2]] : '0;
      chk1("mreq", mreq, e_mreq);
      chk("maddr", maddr, e_maddr);
      chk("mwdata", mwdata, e_mwdata);
      chk1("mwe", mwe, e_mwe);
      chk1("ifready", ifready, e_ifr);
      chk("ifrdata", ifrdata, e_ifd);
      chk1("dready", dready, e_dr);
      chk("drdata", drdata, e_dd);
      if (!reset) begin
`ifdef MEM_ARB_RR_EN
        prefer_d = !last_d;
`else
        prefer_d = 1'b1;
`endif
        if (srv == 0) begin
          if (dreq && (!ifreq || prefer_d)) take_d();
          else if (ifreq) take_if();
        end else if (left == 1) begin
          if (s_we) shadow[s_addr[6:2]] = s_wdata;
          if (srv == 1 && dreq) take_d();
          else if (srv == 2 && ifreq) take_if();
          else srv = 0;
        end else begin
          left--;
        end
      end
    end
  end

  task automatic drain();
    logic r_if, r_d;
    int unsigned n;
    n = 0;
    while ((ifreq || dreq) && n < 40) begin
      r_if = ifready; r_d = dready;
      step();
      if (r_if) ifreq = 1'b0;
      if (r_d) dreq = 1'b0;
      look();
      n++;
    end
    chk1("drain_done", ifreq | dreq, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic r_if, r_d, first_if;
    reset = 1'b1; ifreq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    ifaddr = '0; daddr = '0; dwdata = '0;
    reset1 = 1'b1; ifreq1 = 1'b0; dreq1 = 1'b0; dwe1 = 1'b0;
    ifaddr1 = '0; daddr1 = '0; dwdata1 = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    repeat (2) step();

    // Reset with both requests high, then data wins the first grant.
    ifreq = 1'b1; ifaddr = 32'h08; dreq = 1'b1; dwe = 1'b0; daddr = 32'h10;
    look();
    chk1("rst_mreq", mreq, 1'b0);
    chk1("rst_ready", ifready | dready | mwe, 1'b0);
    chk("rst_maddr", maddr | mwdata | ifrdata | drdata, 32'h0);
    step(); reset = 1'b0; look();
    chk1("rel_idle", mreq, 1'b0);
    step(); look();
    chk1("grant_mreq", mreq, 1'b1);
    chk("grant_maddr", maddr, 32'h10);
    step(); look();
    chk1("both_dready", dready, 1'b1);
    chk("both_drdata", drdata, 32'hA500_0004);
    step(); dreq = 1'b0; look();
    chk("handoff_maddr", maddr, 32'h08);
    chk1("handoff_mreq", mreq, 1'b1);
    step(); look();
    chk1("both_ifready", ifready, 1'b1);
    chk("both_ifrdata", ifrdata, 32'hA500_0002);
    step(); ifreq = 1'b0; look();
    chk1("back_idle", mreq, 1'b0);

    // Single fetch with LATENCY=2.
    step(); ifreq = 1'b1; ifaddr = 32'h04; look();
    chk1("f_t0_mreq", mreq, 1'b0);
    step(); look();
    chk1("f_t1_mreq", mreq, 1'b1);
    chk1("f_t1_ready", ifready, 1'b0);
    step(); look();
    chk1("f_t2_ready", ifready, 1'b1);
    chk("f_t2_data", ifrdata, 32'h2008_0005);
    step(); ifreq = 1'b0; look();
    chk1("f_t3_mreq", mreq, 1'b0);

    // Store then load-back.
    step(); dreq = 1'b1; dwe = 1'b1; daddr = 32'h54; dwdata = 32'd7; look();
    chk1("s_t0_mwe", mwe, 1'b0);
    step(); look();
    chk1("s_t1_mwe", mwe, 1'b0);
    step(); look();
    chk1("s_t2_mwe", mwe, 1'b1);
    chk1("s_t2_dready", dready, 1'b1);
    chk("s_t2_mwdata", mwdata, 32'd7);
    step(); dreq = 1'b0; dwe = 1'b0; look();
    chk("s_mem", mem[21], 32'd7);
    chk1("s_t3_mwe", mwe, 1'b0);
    step(); dreq = 1'b1; look();
    step(); look();
    step(); look();
    chk1("l_dready", dready, 1'b1);
    chk("l_drdata", drdata, 32'd7);
    step(); dreq = 1'b0; look();

    // Tie after a lone data access, then continuous alternation.
    step(); ifreq = 1'b1; ifaddr = 32'h0c; dreq = 1'b1; daddr = 32'h10; look();
    step(); look();
    step(); look();
`ifdef MEM_ARB_RR_EN
    first_if = 1'b1;
`else
    first_if = 1'b0;
`endif
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        if (first_if ^ ((k / 2) % 2 == 1)) chk("alt_ready", {30'b0, ifready, dready}, 32'b10);
        else chk("alt_ready", {30'b0, ifready, dready}, 32'b01);
      end else begin
        chk("alt_gap", {30'b0, ifready, dready}, 32'b00);
      end
      if (k < 11) begin step(); look(); end
    end
    drain();

    // Reset in the middle of a store.
    step(); dreq = 1'b1; dwe = 1'b1; daddr = 32'h58; dwdata = 32'hDEAD_BEEF; look();
    step(); reset = 1'b1; look();
    chk1("rm_mwe", mwe, 1'b0);
    chk1("rm_mreq", mreq, 1'b0);
    chk1("rm_dready", dready, 1'b0);
    step(); reset = 1'b0; dreq = 1'b0; dwe = 1'b0; look();
    chk("rm_mem", mem[22], 32'hA500_0016);
    chk("rm_state", 32'(u0.state_q), 32'(ARB_IDLE));
    step(); look();
    chk("rm_mem2", mem[22], 32'hA500_0016);

    // LATENCY=1 instance: alternating requests complete every cycle.
    step(); ifreq1 = 1'b1; ifaddr1 = 32'h04; dreq1 = 1'b1; daddr1 = 32'h10; look();
    chk("l1_rst", {ifrdata1 | drdata1 | maddr1 | mwdata1}, 32'h0);
    chk("l1_rst_flags", {28'b0, mreq1, mwe1, ifready1, dready1}, 32'h0);
    step(); reset1 = 1'b0; look();
    for (int k = 0; k < 8; k++) begin
      step(); look();
      if (k % 2 == 0) begin
        chk("l1_ready", {30'b0, ifready1, dready1}, 32'b01);
        chk("l1_drdata", drdata1, 32'hA500_0004);
      end else begin
        chk("l1_ready", {30'b0, ifready1, dready1}, 32'b10);
        chk("l1_ifrdata", ifrdata1, 32'h2008_0005);
      end
    end
    step(); reset1 = 1'b1; ifreq1 = 1'b0; dreq1 = 1'b0; look();

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      r_if = ifready; r_d = dready;
      step();
      if (!ifreq || r_if) begin
        ifreq  = ($urandom_range(2) != 0);
        ifaddr = 32'($urandom_range(31)) << 2;
      end
      if (!dreq || r_d) begin
        dreq   = ($urandom_range(2) != 0);
        dwe    = $urandom_range(1) != 0;
        daddr  = 32'($urandom_range(31)) << 2;
        dwdata = $urandom;
      end
      look();
    end
    drain();
    step(); look();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
